// File: rtl/fib_hash_arbiter.sv
// fib_hash_arbiter
//
// Lets the FIB insert path and lookup path share one hash unit. At most one
// requester is granted at a time. Ties go to whoever was not served last. The
// winner's operands are latched and presented to the hash unit. After
// HASH_LATENCY edges the result is captured into the winner's hash register,
// and the winner gets a one-cycle done pulse.
//
// Parameters:
//   HASH_LATENCY   edges from operands on hash inputs to hash_value valid (1..15)
//
// Ports:
//   clk, rst                          clock, synchronous active-low reset
//   ins_req/ins_prefix/ins_len        insert request and operands
//   ins_gnt/ins_done/ins_hash         insert grant pulse, done pulse, result
//   lkp_req/lkp_prefix/lkp_len        lookup request and operands
//   lkp_gnt/lkp_done/lkp_hash         lookup grant pulse, done pulse, result
//   hash_prefix_in/hash_len_in        operands to the hash unit (0 when idle)
//   hash_value                        result from the hash unit
//   busy                              high whenever not idle
module fib_hash_arbiter #(
    parameter int unsigned HASH_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ins_req,
    input  logic [63:0] ins_prefix,
    input  logic [5:0]  ins_len,
    output logic        ins_gnt,
    output logic        ins_done,
    output logic [9:0]  ins_hash,
    input  logic        lkp_req,
    input  logic [63:0] lkp_prefix,
    input  logic [5:0]  lkp_len,
    output logic        lkp_gnt,
    output logic        lkp_done,
    output logic [9:0]  lkp_hash,
    output logic [63:0] hash_prefix_in,
    output logic [5:0]  hash_len_in,
    input  logic [9:0]  hash_value,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StHash, StDone} state_e;

    // Requester encoding used by owner/last: 0 = insert, 1 = lookup.
    localparam logic [3:0] CntLoad = 4'(HASH_LATENCY - 1);

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] op_prefix_q, op_prefix_d;
    logic [5:0]  op_len_q, op_len_d;
    logic        ins_gnt_q, ins_gnt_d;
    logic        lkp_gnt_q, lkp_gnt_d;
    logic        ins_done_q, ins_done_d;
    logic        lkp_done_q, lkp_done_d;
    logic [9:0]  ins_hash_q, ins_hash_d;
    logic [9:0]  lkp_hash_q, lkp_hash_d;
    logic        pick_lkp;

    // Lookup wins if it is the only requester, or on a tie when insert went last.
    assign pick_lkp = lkp_req && (!ins_req || !last_q);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        op_prefix_d = op_prefix_q;
        op_len_d    = op_len_q;
        ins_gnt_d   = 1'b0;
        lkp_gnt_d   = 1'b0;
        ins_done_d  = 1'b0;
        lkp_done_d  = 1'b0;
        ins_hash_d  = ins_hash_q;
        lkp_hash_d  = lkp_hash_q;

        unique case (state_q)
            StIdle: begin
                if (ins_req || lkp_req) begin
                    owner_d     = pick_lkp;
                    last_d      = pick_lkp;
                    op_prefix_d = pick_lkp ? lkp_prefix : ins_prefix;
                    op_len_d    = pick_lkp ? lkp_len : ins_len;
                    cnt_d       = CntLoad;
                    ins_gnt_d   = !pick_lkp;
                    lkp_gnt_d   = pick_lkp;
                    state_d     = StHash;
                end
            end
            StHash: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (owner_q) begin
                        lkp_hash_d = hash_value;
                    end else begin
                        ins_hash_d = hash_value;
                    end
                    ins_done_d = !owner_q;
                    lkp_done_d = owner_q;
                    state_d    = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            owner_q     <= 1'b0;
            last_q      <= 1'b0;
            cnt_q       <= 4'd0;
            op_prefix_q <= 64'd0;
            op_len_q    <= 6'd0;
            ins_gnt_q   <= 1'b0;
            lkp_gnt_q   <= 1'b0;
            ins_done_q  <= 1'b0;
            lkp_done_q  <= 1'b0;
            ins_hash_q  <= 10'd0;
            lkp_hash_q  <= 10'd0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            op_prefix_q <= op_prefix_d;
            op_len_q    <= op_len_d;
            ins_gnt_q   <= ins_gnt_d;
            lkp_gnt_q   <= lkp_gnt_d;
            ins_done_q  <= ins_done_d;
            lkp_done_q  <= lkp_done_d;
            ins_hash_q  <= ins_hash_d;
            lkp_hash_q  <= lkp_hash_d;
        end
    end

    // Hash inputs are forced to 0 in idle so neither path leaks into the unit.
    assign hash_prefix_in = (state_q == StIdle) ? 64'd0 : op_prefix_q;
    assign hash_len_in    = (state_q == StIdle) ? 6'd0 : op_len_q;

    assign ins_gnt  = ins_gnt_q;
    assign lkp_gnt  = lkp_gnt_q;
    assign ins_done = ins_done_q;
    assign lkp_done = lkp_done_q;
    assign ins_hash = ins_hash_q;
    assign lkp_hash = lkp_hash_q;
    assign busy     = (state_q != StIdle);

endmodule
